// File: rtl/l2_cache_pkg.sv
// Shared constants, state encoding and width helper for the set-associative L2 cache.
package l2_cache_pkg;

  localparam int unsigned DEF_LINE_ADDR_W = 28;
  localparam int unsigned DEF_DATA_W      = 128;
  localparam int unsigned DEF_SET_BITS    = 6;
  localparam int unsigned DEF_WAYS        = 2;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WB   = 2'd1;
  localparam state_t FILL = 2'd2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_cache_way.sv
// One way of the cache: per-set valid/dirty flags plus tag and line storage.
module l2_cache_way
  import l2_cache_pkg::*;
#(
  parameter int unsigned SET_BITS = DEF_SET_BITS,
  parameter int unsigned TAG_W    = DEF_LINE_ADDR_W - DEF_SET_BITS,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] idx,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic                we,
  input  logic                install,
  input  logic                wr_dirty,
  input  logic [DATA_W-1:0]   wr_line,
  output logic                hit,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    way_tag,
  output logic [DATA_W-1:0]   line
);

  localparam int unsigned SETS = 1 << SET_BITS;

  logic [SETS-1:0]   valid_arr;
  logic [SETS-1:0]   dirty_arr;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [DATA_W-1:0] line_arr [SETS];

  // Only the status bits are reset; tag/line contents are meaningless while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_arr <= '0;
      dirty_arr <= '0;
    end else if (we) begin
      if (install) valid_arr[idx] <= 1'b1;
      dirty_arr[idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      line_arr[idx] <= wr_line;
      if (install) tag_arr[idx] <= req_tag;
    end
  end

  assign valid   = valid_arr[idx];
  assign dirty   = dirty_arr[idx];
  assign way_tag = tag_arr[idx];
  assign line    = line_arr[idx];
  assign hit     = valid && (tag_arr[idx] == req_tag);

endmodule

// File: rtl/l2_cache_assoc.sv
// Set-associative write-back/write-allocate L2: FSM, victim choice, round-robin pointers, output mux.
module l2_cache_assoc
  import l2_cache_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W = DEF_LINE_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SET_BITS    = DEF_SET_BITS,
  parameter int unsigned WAYS        = DEF_WAYS
) (
  input  logic                   clk,
  input  logic                   L1_reset,
  input  logic                   L1_read,
  input  logic                   L1_write,
  input  logic [LINE_ADDR_W-1:0] L1_addr,
  input  logic [DATA_W-1:0]      L1_wdata,
  output logic                   L1_ready,
  output logic [DATA_W-1:0]      L1_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ready
);

  localparam int unsigned TAG_W = LINE_ADDR_W - SET_BITS;
  localparam int unsigned SETS  = 1 << SET_BITS;
  localparam int unsigned PTR_W = (WAYS > 1) ? clog2(WAYS) : 1;

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  assign idx = L1_addr[SET_BITS-1:0];
  assign tag = L1_addr[LINE_ADDR_W-1:SET_BITS];

  logic [WAYS-1:0]   hit_v, valid_v, dirty_v, we_v;
  logic [TAG_W-1:0]  tag_v  [WAYS];
  logic [DATA_W-1:0] line_v [WAYS];
  logic              install, wr_dirty;
  logic [DATA_W-1:0] wr_line;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    l2_cache_way #(.SET_BITS(SET_BITS), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
      .clk(clk), .rst(L1_reset), .idx(idx), .req_tag(tag),
      .we(we_v[g]), .install(install), .wr_dirty(wr_dirty), .wr_line(wr_line),
      .hit(hit_v[g]), .valid(valid_v[g]), .dirty(dirty_v[g]),
      .way_tag(tag_v[g]), .line(line_v[g])
    );
  end

  state_t           state, state_next;
  logic [PTR_W-1:0] ptr_arr [SETS];
  logic [PTR_W-1:0] vic_q, vic_new, vic, hit_way, inv_way, cur_ptr, ptr_next;
  logic             hit_any, inv_any, latch_vic, ptr_adv, active;

  // Hit way and lowest-index invalid way; victim falls back to the set's round-robin pointer.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (hit_v[w]) begin
        hit_any = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_v[w]) begin
        inv_any = 1'b1;
        inv_way = PTR_W'(w);
      end
    end
  end

  assign cur_ptr  = ptr_arr[idx];
  assign ptr_next = (cur_ptr == PTR_W'(WAYS - 1)) ? '0 : cur_ptr + PTR_W'(1);
  assign vic_new  = inv_any ? inv_way : cur_ptr;
  assign vic      = (state == IDLE) ? vic_new : vic_q;
  assign active   = L1_read ^ L1_write;

  always_comb begin
    state_next = state;
    L1_ready   = 1'b0;
    L1_rdata   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    we_v       = '0;
    install    = 1'b0;
    wr_dirty   = 1'b0;
    wr_line    = L1_wdata;
    latch_vic  = 1'b0;
    ptr_adv    = 1'b0;
    if (!L1_reset) begin
      case (state)
        IDLE: begin
          if (active) begin
            if (hit_any) begin
              L1_ready = 1'b1;
              L1_rdata = line_v[hit_way];
              if (L1_write) begin
                we_v[hit_way] = 1'b1;
                wr_dirty      = 1'b1;
              end
            end else if (dirty_v[vic]) begin
              mem_write  = 1'b1;
              mem_addr   = {tag_v[vic], idx};
              mem_wdata  = line_v[vic];
              latch_vic  = 1'b1;
              state_next = WB;
            end else if (L1_read) begin
              mem_read   = 1'b1;
              mem_addr   = L1_addr;
              latch_vic  = 1'b1;
              state_next = FILL;
            end else begin
              // Full-line write: allocate without fetching from memory.
              we_v[vic] = 1'b1;
              install   = 1'b1;
              wr_dirty  = 1'b1;
              ptr_adv   = 1'b1;
              L1_ready  = 1'b1;
            end
          end
        end
        WB: begin
          if (mem_ready && L1_read) begin
            mem_read   = 1'b1;
            mem_addr   = L1_addr;
            state_next = FILL;
          end else begin
            mem_write = 1'b1;
            mem_addr  = {tag_v[vic], idx};
            mem_wdata = line_v[vic];
            if (mem_ready) begin
              we_v[vic]  = 1'b1;
              install    = 1'b1;
              wr_dirty   = 1'b1;
              ptr_adv    = 1'b1;
              L1_ready   = 1'b1;
              state_next = IDLE;
            end
          end
        end
        FILL: begin
          mem_read = 1'b1;
          mem_addr = L1_addr;
          if (mem_ready) begin
            we_v[vic]  = 1'b1;
            install    = 1'b1;
            wr_line    = mem_rdata;
            ptr_adv    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge L1_reset) begin
    if (L1_reset) begin
      state <= IDLE;
      vic_q <= '0;
      for (int s = 0; s < int'(SETS); s++) ptr_arr[s] <= '0;
    end else begin
      state <= state_next;
      if (latch_vic) vic_q <= vic_new;
      if (ptr_adv) ptr_arr[idx] <= ptr_next;
    end
  end

endmodule

// File: tb/tb_l2_cache_assoc.sv
// Directed bench for l2_cache_assoc: a 2-way default instance and a direct-mapped (WAYS=1) instance.
module tb_l2_cache_assoc;

  localparam int unsigned AW   = 28;
  localparam int unsigned DW   = 128;
  localparam int unsigned WAIT = 3;

  localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] D_5A = {16{8'h5A}};
  localparam logic [DW-1:0] D_C3 = {16{8'hC3}};
  localparam logic [DW-1:0] D_11 = {16{8'h11}};
  localparam logic [DW-1:0] D_22 = {16{8'h22}};
  localparam logic [DW-1:0] D_33 = {16{8'h33}};
  localparam logic [DW-1:0] D_44 = {16{8'h44}};
  localparam logic [DW-1:0] D_77 = {16{8'h77}};
  localparam logic [DW-1:0] D_99 = {16{8'h99}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];

  logic          rdy [2];
  logic          mrd [2];
  logic          mwr [2];
  logic [DW-1:0] rdata [2];
  int            rdc [2];
  int            wrc [2];
  logic [AW-1:0] lwa [2];
  logic [DW-1:0] lwd [2];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 2; g++) begin : gm
    logic          l1_ready, m_read, m_write, m_ready;
    logic [DW-1:0] l1_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] store [256];
    int            cnt, n_rd, n_wr;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    l2_cache_assoc #(.LINE_ADDR_W(AW), .DATA_W(DW), .SET_BITS(6), .WAYS((g == 0) ? 2 : 1)) dut (
      .clk(clk), .L1_reset(rst), .L1_read(rd[g]), .L1_write(wr[g]),
      .L1_addr(addr[g]), .L1_wdata(wdata[g]), .L1_ready(l1_ready), .L1_rdata(l1_rdata),
      .mem_read(m_read), .mem_write(m_write), .mem_addr(m_addr), .mem_wdata(m_wdata),
      .mem_rdata(m_rdata), .mem_ready(m_ready)
    );

    initial begin
      m_ready = 1'b0;
      m_rdata = '0;
      cnt = 0; n_rd = 0; n_wr = 0;
      w_addr = '0; w_data = '0;
      for (int i = 0; i < 256; i++) store[i] = {8{16'(i)}};
      store[1] = D_A5;
      store[2] = D_5A;
      store[3] = D_C3;
    end

    // Memory: WAIT idle cycles per access, then a one-cycle mem_ready that performs the access.
    always @(posedge clk) begin
      #2;
      if (rst) begin
        m_ready = 1'b0;
        cnt = 0;
      end else if (m_ready) begin
        m_ready = 1'b0;
        cnt = (m_read || m_write) ? 1 : 0;
      end else if (m_read || m_write) begin
        if (cnt == int'(WAIT)) begin
          m_ready = 1'b1;
          if (m_write) begin
            store[m_addr[13:6]] = m_wdata;
            n_wr++;
            w_addr = m_addr;
            w_data = m_wdata;
          end else begin
            m_rdata = store[m_addr[13:6]];
            n_rd++;
          end
        end else begin
          cnt++;
        end
      end
    end

    assign rdy[g]   = l1_ready;
    assign mrd[g]   = m_read;
    assign mwr[g]   = m_write;
    assign rdata[g] = l1_rdata;
    assign rdc[g]   = n_rd;
    assign wrc[g]   = n_wr;
    assign lwa[g]   = w_addr;
    assign lwd[g]   = w_data;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Issue one L1 request and return cycles-to-ready (ready cycle included) and read data.
  task automatic do_req(input int u, input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output logic [DW-1:0] q);
    logic got;
    @(negedge clk);
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    lat = 0; q = '0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      lat++;
      if (rdy[u]) begin
        got = 1'b1;
        q = rdata[u];
      end else begin
        @(negedge clk);
      end
    end
    check("ready_seen", DW'(got), DW'(1'b1));
    @(posedge clk);
    #1;
    rd[u] = 1'b0; wr[u] = 1'b0;
  endtask

  task automatic tr(input string tag, input int u, input logic r, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input int exp_lat, input logic [DW-1:0] exp_q);
    int lat;
    logic [DW-1:0] q;
    do_req(u, r, !r, a, d, lat, q);
    check({tag, "_lat"}, DW'(lat), DW'(exp_lat));
    if (r) check({tag, "_data"}, q, exp_q);
  endtask

  initial begin
    int rd0, wr0;
    logic bad;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
    end
    rd[0] = 1'b1; addr[0] = 28'h0000040;
    repeat (2) @(posedge clk);
    #1;
    check("rst_force_ready", DW'(rdy[0]), '0);
    check("rst_force_mread", DW'(mrd[0]), '0);
    rd[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ready", DW'(rdy[0]), '0);
    check("idle_mwrite", DW'(mwr[0]), '0);

    // 2-way instance, all addresses map to set 0.
    tr("cold_read_40", 0, 1'b1, 28'h0000040, '0, 6, D_A5);
    check("cold_read_addr_cnt", DW'(rdc[0]), DW'(1));
    tr("wr_hit_40", 0, 1'b0, 28'h0000040, D_11, 1, '0);
    tr("rd_hit_40", 0, 1'b1, 28'h0000040, '0, 1, D_11);
    check("hit_no_traffic", DW'(rdc[0] + wrc[0]), DW'(1));
    tr("fill_80", 0, 1'b1, 28'h0000080, '0, 6, D_5A);
    tr("evict_c0", 0, 1'b1, 28'h00000C0, '0, 10, D_C3);
    check("wb_count", DW'(wrc[0]), DW'(1));
    check("wb_addr", DW'(lwa[0]), DW'(28'h0000040));
    check("wb_data", lwd[0], D_11);
    tr("still_hit_80", 0, 1'b1, 28'h0000080, '0, 1, D_5A);

    rd0 = rdc[0]; wr0 = wrc[0];
    tr("wr_miss_clean_1000", 0, 1'b0, 28'h0001000, D_77, 1, '0);
    check("wr_miss_no_traffic", DW'(rdc[0] + wrc[0]), DW'(rd0 + wr0));
    tr("rd_1000", 0, 1'b1, 28'h0001000, '0, 1, D_77);

    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 28'h0000040;
    bad = 1'b0;
    repeat (3) begin
      #1;
      if (rdy[0] || mrd[0] || mwr[0]) bad = 1'b1;
      @(negedge clk);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    check("both_high_quiet", DW'(bad), '0);

    tr("wr_miss_clean_80", 0, 1'b0, 28'h0000080, D_99, 1, '0);
    tr("wr_miss_dirty_40", 0, 1'b0, 28'h0000040, D_44, 5, '0);
    check("wr_wb_addr", DW'(lwa[0]), DW'(28'h0001000));
    check("wr_wb_data", lwd[0], D_77);
    tr("rd_hit_40_new", 0, 1'b1, 28'h0000040, '0, 1, D_44);

    // Direct-mapped instance: 0x40/0x80 evict each other with write-back.
    tr("dm_read_40", 1, 1'b1, 28'h0000040, '0, 6, D_A5);
    tr("dm_wr_40", 1, 1'b0, 28'h0000040, D_22, 1, '0);
    tr("dm_read_80", 1, 1'b1, 28'h0000080, '0, 10, D_5A);
    check("dm_wb1_addr", DW'(lwa[1]), DW'(28'h0000040));
    check("dm_wb1_data", lwd[1], D_22);
    tr("dm_wr_80", 1, 1'b0, 28'h0000080, D_33, 1, '0);
    tr("dm_read_40_back", 1, 1'b1, 28'h0000040, '0, 10, D_22);
    check("dm_wb2_addr", DW'(lwa[1]), DW'(28'h0000080));
    check("dm_wb2_data", lwd[1], D_33);

    // Reset during FILL on the 2-way instance.
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 28'h0000041;
    @(negedge clk);
    #1;
    check("fill_mread_high", DW'(mrd[0]), DW'(1'b1));
    rst = 1'b1;
    #1;
    check("rst_mread_drop", DW'(mrd[0]), '0);
    check("rst_ready_low", DW'(rdy[0]), '0);
    @(negedge clk);
    rst = 1'b0;
    rd[0] = 1'b0;
    tr("post_rst_41", 0, 1'b1, 28'h0000041, '0, 6, D_11);
    tr("post_rst_80", 0, 1'b1, 28'h0000080, '0, 6, D_5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_cache_assoc.md
# l2_cache_assoc

Parametrised set-associative, write-back, write-allocate L2 cache between the L1 line interface and main memory; successor to the direct-mapped 64-line L2. Adds configurable set count and associativity, per-set round-robin replacement, and write-miss install without a memory fetch, since L1 always writes full lines. Port protocol on both sides is unchanged, so the block drops into the existing L1/memory hierarchy.

## Interface
- LINE_ADDR_W, 28: line address width; byte offset is already stripped by L1.
- DATA_W, 128: line width in bits.
- SET_BITS, 6: index width; SETS = 2**SET_BITS; legal range 1..8.
- WAYS, 2: associativity; legal values 1, 2, 4.
- TAG_W: derived, LINE_ADDR_W-SET_BITS; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- L1_reset  in  1  reset, asynchronous, active-high.
- L1_read  in  1  L1 line read request; held until L1_ready.
- L1_write  in  1  L1 line write request; held until L1_ready.
- L1_addr  in  LINE_ADDR_W  line address; index = [SET_BITS-1:0], tag = upper bits.
- L1_wdata  in  DATA_W  full-line write data.
- L1_ready  out  1  request complete this cycle.
- L1_rdata  out  DATA_W  read data; valid only while L1_ready && L1_read.
- mem_read  out  1  memory line read; held until mem_ready.
- mem_write  out  1  memory line write; held until mem_ready.
- mem_addr  out  LINE_ADDR_W  memory line address.
- mem_wdata  out  DATA_W  write-back data.
- mem_rdata  in  DATA_W  fill data; valid with mem_ready.
- mem_ready  in  1  memory completes the current access.

## Operation
- Per way, per set: valid, dirty, tag, line. Per set: victim pointer, log2(WAYS) bits; 0 bits when WAYS=1.
- A request is active when L1_read ^ L1_write. Both high or both low: no action, all outputs 0.
- Hit: some way is valid with a matching tag; at most one way can match.
- Victim: the first invalid way, lowest index; if every way is valid, the way at the set's victim pointer.
- FSM states: IDLE, WB, FILL.
- IDLE, hit: L1_ready=1, L1_rdata=hit line. A write updates the line and sets dirty. State stays IDLE.
- IDLE, miss, victim dirty: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line. Next state WB.
- IDLE, miss, victim clean, read: mem_read=1, mem_addr=L1_addr. Next state FILL.
- IDLE, miss, victim clean, write: install L1_wdata into the victim way. Tag is set, valid=1, dirty=1, the victim pointer advances, and L1_ready=1 in the same cycle. No memory access. State stays IDLE.
- WB: hold the mem_write outputs until mem_ready. On mem_ready:
  - read: drive mem_read=1, mem_addr=L1_addr in that same cycle, then go to FILL.
  - write: install L1_wdata, dirty=1, pointer advances, L1_ready=1, then go to IDLE.
- FILL: hold mem_read until mem_ready. On mem_ready: write mem_rdata into the victim way, tag set, valid=1, dirty=0, pointer advances, then go to IDLE. The re-lookup next cycle hits and returns the data.
- The victim way is latched on leaving IDLE and is not recomputed in WB or FILL.
- L1 holds address, command and data constant from request until L1_ready; the block does not check this.

## Timing
- Reset: state=IDLE; every valid, dirty and victim pointer cleared. Tag and data arrays are not reset.
- While L1_reset is high, all outputs are forced to 0.
- Reset asserted mid-WB or mid-FILL aborts the memory access immediately; the memory model must tolerate the request dropping.
- All outputs are combinational from state, arrays and inputs; no output registers.
- Read hit latency 0: L1_ready in the cycle of the request.
- Clean read miss: 1 IDLE cycle + (N+1) FILL cycles + 1 IDLE hit cycle, where N = memory wait cycles.
- Dirty read miss: WB(M+1) cycles precede FILL.
- Clean write miss: 0 latency.
- Dirty write miss: ready on the WB mem_ready cycle.
- mem_read and mem_write are never high together.
- mem_ready outside WB/FILL is ignored.

## Structure
- Package l2_cache_pkg holds:
  - state enum {IDLE, WB, FILL};
  - default width constants;
  - a clog2 helper for the pointer width.
- Sub-module l2_cache_way, instantiated WAYS times. Each holds one way's valid/dirty/tag/data arrays and exposes:
  - hit;
  - read line/tag/dirty at an index;
  - write enable with install/update controls.
- The top level holds the FSM, victim selection, pointer array and output muxing.

## Test plan
- Defaults, after reset: read 0x0000040 -> mem_read, mem_addr 0x0000040; mem_ready after 3 cycles with 0xA5..A5; next cycle L1_ready=1, L1_rdata=0xA5..A5.
- Write hit to 0x0000040 with 0x11..11, then read -> ready same cycle both times, rdata 0x11..11, no memory traffic.
- Fill 0x0000040 and 0x0000080 (same set, both ways), then read 0x00000C0 -> way 0 evicted. A dirty way 0 first produces mem_write at 0x0000040 with its data, then mem_read at 0x00000C0; 0x0000080 still hits afterwards.
- Write miss, clean victim, to 0x0001000 -> L1_ready same cycle, no mem_read/mem_write; a later read returns the written data.
- L1_read and L1_write both high -> no ready, no memory access. WAYS=1 config: conflicting addresses 0x40/0x80 alternate-evict with write-back.
- L1_reset pulsed during FILL -> mem_read drops immediately; a subsequent read of the same address misses.
